rv_lsu: RTL
===========

# rv_lsu

Parametrised load/store unit that sits between the multicycle RISC-V core and data memory, replacing the direct word-only `Adr`/`WriteData`/`MemWrite` connection.

- Accepts one access request at a time from the core controller.
- Handles memories with variable latency through a req/ack handshake.
- Generates byte enables and lane-shifted store data; sign- or zero-extends load data per `funct3`.
- Flags misaligned, illegal-width and timed-out accesses.

## Interface
Parameters:
- DATA_W, 32, data path width; legal values 32 or 64. Byte-enable width BE_W = DATA_W/8; lane-offset bits OFS = log2(BE_W).
- ADDR_W, 32, address width.
- TIMEOUT, 255, maximum cycles `mem_req` may wait for `mem_ack` before the access is aborted; must be ≥ 1.

Ports:
- clk  in  1  single clock, rising edge.
- reset  in  1  asynchronous, active-high reset.
- core_req  in  1  access request; sampled only in IDLE.
- core_we  in  1  1 = store, 0 = load.
- core_addr  in  ADDR_W  byte address.
- core_wdata  in  DATA_W  store data, right-aligned.
- core_funct3  in  3  access size/sign (RISC-V load/store `funct3`).
- core_rdata  out  DATA_W  extended load result; valid while `core_done` = 1 and held until the next `core_done`.
- core_done  out  1  one-cycle completion pulse.
- core_err  out  1  one-cycle error pulse, coincident with `core_done`.
- busy  out  1  high from the cycle after acceptance through the `core_done` cycle.
- mem_req  out  1  memory request, held until ack or timeout.
- mem_we  out  1  store qualifier.
- mem_addr  out  ADDR_W  `core_addr` with the low OFS bits forced to 0.
- mem_be  out  BE_W  byte enables.
- mem_wdata  out  DATA_W  store data shifted to the addressed lane.
- mem_rdata  in  DATA_W  read data, valid with `mem_ack`.
- mem_ack  in  1  memory completion; meaningful only while `mem_req` = 1.

## Operation
FSM states: IDLE, ACCESS, DONE.

IDLE
- `core_req` = 1 latches we, addr, wdata and funct3, then decodes them.
- Legal loads: 000 LB, 001 LH, 010 LW, 100 LBU, 101 LHU. DATA_W = 64 adds 011 LD and 110 LWU.
- Legal stores: 000 SB, 001 SH, 010 SW. DATA_W = 64 adds 011 SD.
- Any other encoding is illegal.
- Misaligned: halfword with addr[0] ≠ 0; word with addr[1:0] ≠ 0; doubleword with addr[2:0] ≠ 0.
- Illegal or misaligned: go to DONE with err set; no memory access is made.
- Otherwise: go to ACCESS.

ACCESS
- Drive `mem_req` = 1 with mem_we, mem_addr, mem_be and mem_wdata.
- `mem_be` = size mask (1/3/0xF/0xFF) << addr[OFS-1:0].
- `mem_wdata` = wdata << (8·addr[OFS-1:0]).
- On `mem_ack`:
  - Capture `mem_rdata` >> (8·offset), truncated to the access size.
  - Sign-extend for LB/LH/LW(64); zero-extend for LBU/LHU/LWU.
  - Stores return `core_rdata` = 0.
  - Go to DONE.
- Wait counter increments each ACCESS cycle without ack. Reaching TIMEOUT: drop `mem_req`, set err, go to DONE.

DONE
- Pulse `core_done` (plus `core_err` if err), then return to IDLE.

Side rules
- `core_req` is ignored outside IDLE.
- `mem_ack` is ignored outside ACCESS.
- All `mem_*` outputs are 0 when `mem_req` = 0.

## Timing
- Reset (asynchronous): state IDLE; all outputs 0, including `core_rdata`; counter 0.
- Reset asserted mid-access drops `mem_req` immediately. No `core_done` is produced for the aborted access.
- Best case: `core_req` at cycle 0, `mem_req` at cycle 1, `mem_ack` at cycle 1, `core_done` at cycle 2. Latency = 2 + wait cycles.
- Error path (misaligned/illegal): `core_done` and `core_err` at cycle 1; `mem_req` never asserted.
- Timeout: `mem_req` is high for exactly TIMEOUT cycles. `core_done` and `core_err` follow in the next cycle.
- `mem_ack` in the same cycle the counter reaches TIMEOUT: the ack wins and the access completes normally.
- Back-to-back: `core_req` may be held high. A new access is accepted in the IDLE cycle after DONE, giving 3-cycle throughput with zero-wait memory.

## Test plan
- LW, addr 0x100, zero-wait memory returning 0xDEADBEEF → `mem_be` = 0xF, `core_done` at cycle 2, `core_rdata` = 0xDEADBEEF, `core_err` = 0.
- LB at 0x103, then LBU at 0x103, memory word 0x80FF_0000 → `mem_be` = 0x8; rdata 0xFFFFFF80 for LB, 0x00000080 for LBU.
- SH at 0x102 with wdata 0x0000ABCD → `mem_be` = 0xC, `mem_wdata` = 0xABCD0000, `mem_we` = 1.
- LW at 0x101, and funct3 = 111 → `core_err` and `core_done` at cycle 1; `mem_req` never asserted.
- TIMEOUT = 4, memory never acks → `mem_req` high for 4 cycles, then `core_err` pulse. A late `mem_ack` afterwards is ignored.
- Reset asserted during ACCESS with a 3-wait memory → `mem_req` and `busy` drop the same cycle; no `core_done`. After reset release, a new LW completes normally.

Source files
------------

// File: rtl/rv_lsu.sv
// rtl/rv_lsu.sv - load/store unit between the multicycle RISC-V core and variable-latency data memory
module rv_lsu #(
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 32,
  parameter int TIMEOUT = 255
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   core_req,
  input  logic                   core_we,
  input  logic [ADDR_W-1:0]      core_addr,
  input  logic [DATA_W-1:0]      core_wdata,
  input  logic [2:0]             core_funct3,
  output logic [DATA_W-1:0]      core_rdata,
  output logic                   core_done,
  output logic                   core_err,
  output logic                   busy,
  output logic                   mem_req,
  output logic                   mem_we,
  output logic [ADDR_W-1:0]      mem_addr,
  output logic [DATA_W/8-1:0]    mem_be,
  output logic [DATA_W-1:0]      mem_wdata,
  input  logic [DATA_W-1:0]      mem_rdata,
  input  logic                   mem_ack
);

  localparam int BE_W  = DATA_W / 8;
  localparam int OFS   = $clog2(BE_W);
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam bit IS64  = (DATA_W == 64);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_DONE
  } state_t;

  state_t              state, state_next;
  logic                we_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [DATA_W-1:0]   wdata_q;
  logic [2:0]          f3_q;
  logic                err_q, err_next;
  logic [CNT_W-1:0]    cnt, cnt_next;
  logic [DATA_W-1:0]   rdata_q, rdata_next;
  logic                load_en;

  logic                legal;
  logic                misaligned;
  logic                dec_err;
  logic [OFS-1:0]      off;
  logic [BE_W-1:0]     size_mask;
  logic [DATA_W-1:0]   rd_shifted;
  logic [DATA_W-1:0]   load_ext;

  // Decode is done on the live core inputs so the error path can reach DONE in one cycle.
  always_comb begin
    legal = 1'b0;
    if (core_we) begin
      case (core_funct3)
        3'b000, 3'b001, 3'b010: legal = 1'b1;
        3'b011:                 legal = IS64;
        default:                legal = 1'b0;
      endcase
    end else begin
      case (core_funct3)
        3'b000, 3'b001, 3'b010, 3'b100, 3'b101: legal = 1'b1;
        3'b011, 3'b110:                         legal = IS64;
        default:                                legal = 1'b0;
      endcase
    end
    case (core_funct3[1:0])
      2'd1:    misaligned = core_addr[0];
      2'd2:    misaligned = (core_addr[1:0] != 2'b00);
      2'd3:    misaligned = (core_addr[2:0] != 3'b000);
      default: misaligned = 1'b0;
    endcase
    dec_err = !legal || misaligned;
  end

  always_comb begin
    off = addr_q[OFS-1:0];
    case (f3_q[1:0])
      2'd0:    size_mask = BE_W'(1);
      2'd1:    size_mask = BE_W'(3);
      2'd2:    size_mask = BE_W'(15);
      default: size_mask = '1;
    endcase
    rd_shifted = mem_rdata >> {off, 3'b000};
    case (f3_q)
      3'b000:  load_ext = DATA_W'($signed(rd_shifted[7:0]));
      3'b001:  load_ext = DATA_W'($signed(rd_shifted[15:0]));
      3'b010:  load_ext = DATA_W'($signed(rd_shifted[31:0]));
      3'b100:  load_ext = DATA_W'(rd_shifted[7:0]);
      3'b101:  load_ext = DATA_W'(rd_shifted[15:0]);
      3'b110:  load_ext = DATA_W'(rd_shifted[31:0]);
      default: load_ext = rd_shifted;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state   <= S_IDLE;
      err_q   <= 1'b0;
      cnt     <= '0;
      rdata_q <= '0;
    end else begin
      state   <= state_next;
      err_q   <= err_next;
      cnt     <= cnt_next;
      rdata_q <= rdata_next;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      f3_q    <= '0;
    end else if (load_en) begin
      we_q    <= core_we;
      addr_q  <= core_addr;
      wdata_q <= core_wdata;
      f3_q    <= core_funct3;
    end
  end

  // An ack in the final allowed cycle takes priority over the timeout.
  always_comb begin
    state_next = state;
    err_next   = err_q;
    cnt_next   = cnt;
    rdata_next = rdata_q;
    load_en    = 1'b0;
    case (state)
      S_IDLE: begin
        if (core_req) begin
          load_en  = 1'b1;
          err_next = dec_err;
          cnt_next = '0;
          if (dec_err) begin
            rdata_next = '0;
            state_next = S_DONE;
          end else begin
            state_next = S_ACCESS;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          rdata_next = we_q ? '0 : load_ext;
          err_next   = 1'b0;
          state_next = S_DONE;
        end else if (cnt == CNT_W'(TIMEOUT - 1)) begin
          rdata_next = '0;
          err_next   = 1'b1;
          state_next = S_DONE;
        end else begin
          cnt_next = cnt + CNT_W'(1);
        end
      end
      S_DONE: begin
        state_next = S_IDLE;
      end
      default: begin
        state_next = S_IDLE;
      end
    endcase
  end

  always_comb begin
    mem_req    = (state == S_ACCESS);
    mem_we     = mem_req && we_q;
    mem_addr   = mem_req ? {addr_q[ADDR_W-1:OFS], {OFS{1'b0}}} : '0;
    mem_be     = mem_req ? (size_mask << off) : '0;
    mem_wdata  = mem_req ? (wdata_q << {off, 3'b000}) : '0;
    core_done  = (state == S_DONE);
    core_err   = core_done && err_q;
    busy       = (state != S_IDLE);
    core_rdata = rdata_q;
  end

endmodule
